// File: rtl/cmos_frame_seq.sv
// Frame/line timing sequencer for the CMOS test-pattern generator.
// Optional abort port pair is enabled by defining CMOS_FRAME_SEQ_ABORT_EN.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for start, config not yet latched
// VBLANK   | pre-frame blanking, counts vblank ticks
// ACTIVE   | line active, one pixel per pix_tick
// HBLANK   | inter-line blanking inside a frame
// DONE     | one-cycle completion pulse, then back to IDLE
module cmos_frame_seq #(
    parameter int PIX_W   = 12,
    parameter int LINE_W  = 12,
    parameter int BLANK_W = 10,
    parameter int FRM_W   = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               pix_tick,
    input  logic               start,
    input  logic               stop,
`ifdef CMOS_FRAME_SEQ_ABORT_EN
    input  logic               abort,
    output logic               abort_ack,
`endif
    input  logic [PIX_W-1:0]   cfg_pix,
    input  logic [LINE_W-1:0]  cfg_lines,
    input  logic [BLANK_W-1:0] cfg_hblank,
    input  logic [BLANK_W-1:0] cfg_vblank,
    input  logic [FRM_W-1:0]   cfg_frames,
    output logic               frame_valid,
    output logic               line_valid,
    output logic               pix_en,
    output logic [PIX_W-1:0]   pix_x,
    output logic [LINE_W-1:0]  line_y,
    output logic [FRM_W-1:0]   frame_num,
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VBLANK = 3'd1;
    localparam logic [2:0] S_ACTIVE = 3'd2;
    localparam logic [2:0] S_HBLANK = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]         state;
    logic [PIX_W-1:0]   pix_r;
    logic [PIX_W-1:0]   x;
    logic [LINE_W-1:0]  lines_r;
    logic [BLANK_W-1:0] hblank_r;
    logic [BLANK_W-1:0] vblank_r;
    logic [BLANK_W-1:0] blank_cnt;
    logic [FRM_W-1:0]   frames_r;
    logic               stop_pend;
    logic               abort_hit;
    logic               last_pix;
    logic               last_line;
    logic [FRM_W-1:0]   frame_next;
    logic               finish;

`ifdef CMOS_FRAME_SEQ_ABORT_EN
    assign abort_hit = abort && (state != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign last_pix   = (x == pix_r - PIX_W'(1));
    assign last_line  = (line_y == lines_r - LINE_W'(1));
    assign frame_next = frame_num + FRM_W'(1);
    // A stop arriving on the very last pixel tick still ends the run at this frame.
    assign finish     = ((frames_r != '0) && (frame_next == frames_r)) || stop_pend || stop;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= S_IDLE;
            pix_r       <= '0;
            x           <= '0;
            lines_r     <= '0;
            hblank_r    <= '0;
            vblank_r    <= '0;
            blank_cnt   <= '0;
            frames_r    <= '0;
            stop_pend   <= 1'b0;
            frame_valid <= 1'b0;
            line_valid  <= 1'b0;
            pix_en      <= 1'b0;
            pix_x       <= '0;
            line_y      <= '0;
            frame_num   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef CMOS_FRAME_SEQ_ABORT_EN
            abort_ack   <= 1'b0;
`endif
        end else begin
            pix_en <= 1'b0;
            done   <= 1'b0;
`ifdef CMOS_FRAME_SEQ_ABORT_EN
            abort_ack <= 1'b0;
`endif
            if (abort_hit) begin
                state       <= S_IDLE;
                frame_valid <= 1'b0;
                line_valid  <= 1'b0;
                busy        <= 1'b0;
                stop_pend   <= 1'b0;
`ifdef CMOS_FRAME_SEQ_ABORT_EN
                abort_ack   <= 1'b1;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        stop_pend <= 1'b0;
                        if (start) begin
                            pix_r     <= (cfg_pix == '0)    ? PIX_W'(1)   : cfg_pix;
                            lines_r   <= (cfg_lines == '0)  ? LINE_W'(1)  : cfg_lines;
                            hblank_r  <= (cfg_hblank == '0) ? BLANK_W'(1) : cfg_hblank;
                            vblank_r  <= (cfg_vblank == '0) ? BLANK_W'(1) : cfg_vblank;
                            frames_r  <= cfg_frames;
                            blank_cnt <= '0;
                            frame_num <= '0;
                            busy      <= 1'b1;
                            state     <= S_VBLANK;
                        end
                    end
                    S_VBLANK: begin
                        if (stop) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else if (pix_tick) begin
                            if (blank_cnt == vblank_r - BLANK_W'(1)) begin
                                frame_valid <= 1'b1;
                                line_valid  <= 1'b1;
                                x           <= '0;
                                line_y      <= '0;
                                state       <= S_ACTIVE;
                            end else begin
                                blank_cnt <= blank_cnt + BLANK_W'(1);
                            end
                        end
                    end
                    S_ACTIVE: begin
                        if (stop) stop_pend <= 1'b1;
                        if (pix_tick) begin
                            pix_en <= 1'b1;
                            pix_x  <= x;
                            x      <= x + PIX_W'(1);
                            if (last_pix) begin
                                blank_cnt  <= '0;
                                line_valid <= 1'b0;
                                if (!last_line) begin
                                    state <= S_HBLANK;
                                end else begin
                                    frame_valid <= 1'b0;
                                    frame_num   <= frame_next;
                                    done        <= finish;
                                    state       <= finish ? S_DONE : S_VBLANK;
                                end
                            end
                        end
                    end
                    S_HBLANK: begin
                        if (stop) stop_pend <= 1'b1;
                        if (pix_tick) begin
                            if (blank_cnt == hblank_r - BLANK_W'(1)) begin
                                line_valid <= 1'b1;
                                x          <= '0;
                                line_y     <= line_y + LINE_W'(1);
                                state      <= S_ACTIVE;
                            end else begin
                                blank_cnt <= blank_cnt + BLANK_W'(1);
                            end
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmos_frame_seq.sv
// Directed bench for cmos_frame_seq: vector table of whole runs plus hand sequences.
module tb_cmos_frame_seq;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        pix_tick;
    logic        start;
    logic        stop;
    logic [11:0] cfg_pix;
    logic [11:0] cfg_lines;
    logic [9:0]  cfg_hblank;
    logic [9:0]  cfg_vblank;
    logic [15:0] cfg_frames;
    logic        frame_valid;
    logic        line_valid;
    logic        pix_en;
    logic [11:0] pix_x;
    logic [11:0] line_y;
    logic [15:0] frame_num;
    logic        busy;
    logic        done;
`ifdef CMOS_FRAME_SEQ_ABORT_EN
    logic        abort;
    logic        abort_ack;
`endif

    int total = 0;
    int bad   = 0;

    cmos_frame_seq dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .pix_tick   (pix_tick),
        .start      (start),
        .stop       (stop),
`ifdef CMOS_FRAME_SEQ_ABORT_EN
        .abort      (abort),
        .abort_ack  (abort_ack),
`endif
        .cfg_pix    (cfg_pix),
        .cfg_lines  (cfg_lines),
        .cfg_hblank (cfg_hblank),
        .cfg_vblank (cfg_vblank),
        .cfg_frames (cfg_frames),
        .frame_valid(frame_valid),
        .line_valid (line_valid),
        .pix_en     (pix_en),
        .pix_x      (pix_x),
        .line_y     (line_y),
        .frame_num  (frame_num),
        .busy       (busy),
        .done       (done)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int pix, lines, hb, vb, frames, div;
        int exp_fv, exp_lv, exp_pen, exp_fn;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic set_cfg(input int p, input int l, input int hb, input int vb, input int fr);
        cfg_pix    = 12'(p);
        cfg_lines  = 12'(l);
        cfg_hblank = 10'(hb);
        cfg_vblank = 10'(vb);
        cfg_frames = 16'(fr);
    endtask

    // Observes one run (start already driven) until busy drops, tallying framing.
    task automatic watch(input int div, input int pixe, input int linese, input int budget,
                         input bit do_stop, output int fv_cyc, output int lv_cyc,
                         output int pen, output int dones, output int xy_bad,
                         output int hold_bad, output bit tmo);
        int  cyc = 0;
        int  k;
        bit  last_tick;
        bit  stopped = 0;
        logic prev_fv;
        fv_cyc = 0; lv_cyc = 0; pen = 0; dones = 0; xy_bad = 0; hold_bad = 0; tmo = 0;
        last_tick = pix_tick;
        prev_fv   = frame_valid;
        forever begin
            @(negedge sys_clk);
            start = 1'b0;
            stop  = 1'b0;
            if (frame_valid) fv_cyc++;
            if (line_valid) lv_cyc++;
            if (pix_en) begin
                k = pen % (pixe * linese);
                if (int'(pix_x) != k % pixe || int'(line_y) != k / pixe) xy_bad++;
                pen++;
            end
            if (!last_tick && (pix_en || frame_valid != prev_fv)) hold_bad++;
            if (done) dones++;
            if (do_stop && !stopped && frame_num == 16'd1 && line_y == 12'd1 && line_valid) begin
                stop    = 1'b1;
                stopped = 1;
            end
            prev_fv = frame_valid;
            if (!busy) break;
            cyc++;
            if (cyc > budget) begin
                tmo = 1;
                break;
            end
            pix_tick  = ((cyc % div) == 0);
            last_tick = pix_tick;
        end
        pix_tick = 1'b1;
    endtask

    initial begin
        int fv_cyc, lv_cyc, pen, dones, xy_bad, hold_bad, n, cnt, vbc;
        bit tmo;

        vecs[0] = '{pix:4, lines:2, hb:2, vb:3, frames:1, div:1, exp_fv:10, exp_lv:8,  exp_pen:8, exp_fn:1};
        vecs[1] = '{pix:4, lines:2, hb:2, vb:3, frames:1, div:3, exp_fv:30, exp_lv:24, exp_pen:8, exp_fn:1};
        vecs[2] = '{pix:0, lines:3, hb:1, vb:1, frames:1, div:1, exp_fv:5,  exp_lv:3,  exp_pen:3, exp_fn:1};
        vecs[3] = '{pix:3, lines:1, hb:0, vb:0, frames:2, div:1, exp_fv:6,  exp_lv:6,  exp_pen:6, exp_fn:2};
        vecs[4] = '{pix:2, lines:2, hb:3, vb:2, frames:1, div:2, exp_fv:14, exp_lv:8,  exp_pen:4, exp_fn:1};

        sys_rst = 1'b1; pix_tick = 1'b1; start = 1'b0; stop = 1'b0;
`ifdef CMOS_FRAME_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        set_cfg(0, 0, 0, 0, 0);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("rst_fv", frame_valid, 0);
        chk("rst_lv_pen", {line_valid, pix_en}, 0);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_counts", {pix_x, line_y, frame_num}, 0);

        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            set_cfg(vecs[i].pix, vecs[i].lines, vecs[i].hb, vecs[i].vb, vecs[i].frames);
            start = 1'b1; pix_tick = 1'b1;
            watch(vecs[i].div, (vecs[i].pix == 0) ? 1 : vecs[i].pix, vecs[i].lines, 2000, 0,
                  fv_cyc, lv_cyc, pen, dones, xy_bad, hold_bad, tmo);
            chk($sformatf("v%0d_timeout", i), tmo, 0);
            chk($sformatf("v%0d_fv_cycles", i), fv_cyc, vecs[i].exp_fv);
            chk($sformatf("v%0d_lv_cycles", i), lv_cyc, vecs[i].exp_lv);
            chk($sformatf("v%0d_pix_en", i), pen, vecs[i].exp_pen);
            chk($sformatf("v%0d_xy", i), xy_bad, 0);
            chk($sformatf("v%0d_hold", i), hold_bad, 0);
            chk($sformatf("v%0d_done", i), dones, 1);
            chk($sformatf("v%0d_frame_num", i), frame_num, vecs[i].exp_fn);
        end

        // Continuous mode, stop in line 1 of frame 2: frame finishes, run ends.
        @(negedge sys_clk);
        set_cfg(4, 2, 2, 3, 0);
        start = 1'b1;
        watch(1, 4, 2, 2000, 1, fv_cyc, lv_cyc, pen, dones, xy_bad, hold_bad, tmo);
        chk("stop_timeout", tmo, 0);
        chk("stop_pix_en", pen, 16);
        chk("stop_fv_cycles", fv_cyc, 20);
        chk("stop_done", dones, 1);
        chk("stop_frame_num", frame_num, 2);
        cnt = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (frame_valid || busy) cnt++;
        end
        chk("stop_quiet_after", cnt, 0);

        // Stop during VBLANK: DONE on the next cycle, no frame.
        @(negedge sys_clk);
        set_cfg(4, 2, 2, 5, 1);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        chk("vbstop_busy", busy, 1);
        stop = 1'b1;
        @(negedge sys_clk);
        stop = 1'b0;
        chk("vbstop_done", done, 1);
        chk("vbstop_fv", frame_valid, 0);
        @(negedge sys_clk);
        chk("vbstop_idle", {busy, done, frame_valid}, 0);
        chk("vbstop_frame_num", frame_num, 0);

        // Start re-pulsed while busy with new config: no restart, no relatch.
        @(negedge sys_clk);
        set_cfg(4, 1, 1, 4, 1);
        start = 1'b1;
        n = 0; vbc = 0; pen = 0; tmo = 0;
        forever begin
            @(negedge sys_clk);
            n++;
            start = 1'b0;
            if (n == 2) begin
                start = 1'b1;
                set_cfg(2, 1, 1, 1, 1);
            end
            if (busy && !frame_valid && pen == 0 && !line_valid) vbc++;
            if (pix_en) pen++;
            if (!busy) break;
            if (n > 500) begin tmo = 1; break; end
        end
        chk("rebusy_timeout", tmo, 0);
        chk("rebusy_vblank_cycles", vbc, 4);
        chk("rebusy_pix_en", pen, 4);

        // Synchronous reset mid-ACTIVE.
        @(negedge sys_clk);
        set_cfg(8, 2, 1, 1, 1);
        start = 1'b1;
        n = 0; tmo = 0;
        forever begin
            @(negedge sys_clk);
            start = 1'b0;
            n++;
            if (pix_en && pix_x == 12'd2) break;
            if (n > 500) begin tmo = 1; break; end
        end
        chk("midrst_timeout", tmo, 0);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        chk("midrst_flags", {frame_valid, line_valid, pix_en, busy, done}, 0);
        chk("midrst_counts", {pix_x, line_y, frame_num}, 0);

`ifdef CMOS_FRAME_SEQ_ABORT_EN
        @(negedge sys_clk);
        set_cfg(4, 2, 2, 3, 1);
        start = 1'b1;
        n = 0; tmo = 0;
        forever begin
            @(negedge sys_clk);
            start = 1'b0;
            n++;
            if (pix_en && pix_x == 12'd1 && line_y == 12'd0) break;
            if (n > 500) begin tmo = 1; break; end
        end
        chk("abort_timeout", tmo, 0);
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
        chk("abort_flags", {frame_valid, line_valid, busy, done}, 0);
        chk("abort_ack", abort_ack, 1);
        @(negedge sys_clk);
        chk("abort_ack_once", {abort_ack, done, busy}, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
